aes_key_expand: RTL and testbench
=================================

# aes_key_expand

Iterative AES-128 key-schedule engine that sits directly upstream of the AES round datapath and supplies its per-round 128-bit round key. It loads a cipher key and presents round key 0. Then, on each request, it computes the next round key in place, up to round key 10. The SubWord step is serialised through a single shared S-box, one byte per cycle, to match the area-lean serial style of the round stages.

## Interface
Parameters:
- none (AES-128 only; `NR = 10` is a package constant)

Ports:
- `clk_i`  in  1  single clock; all state changes on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `key_i`  in  128  cipher key, sampled only when `load_i` is accepted; `w0 = key_i[127:96]`
- `load_i`  in  1  load `key_i` as round key 0; accepted in any state
- `next_i`  in  1  request the next round key; accepted only when `valid_o=1` and `last_o=0`
- `round_key_o`  out  128  current round key; stable whenever `valid_o=1`
- `round_idx_o`  out  4  index (0..10) of the key on `round_key_o`
- `valid_o`  out  1  `round_key_o` holds a complete key for `round_idx_o`
- `busy_o`  out  1  a next-key computation is in progress
- `last_o`  out  1  `round_idx_o == 10` and `valid_o=1`

## Operation
- FSM states: IDLE, SUB, XOR, READY.
- **IDLE**
  - Reset state; `valid_o=0`.
  - `load_i` moves the FSM to READY.
- **READY**
  - `valid_o=1`.
  - `load_i` moves the FSM back to READY with the new key.
  - Otherwise, `next_i` with `round_idx_o<10` moves the FSM to SUB with the 2-bit byte counter cleared. `valid_o` and `last_o` drop.
  - `next_i` while `last_o=1` is ignored; key and index are held.
- **SUB**
  - `temp = RotWord(w3) = {w3[23:0], w3[31:24]}`.
  - Each cycle, byte `cnt` of `temp`, counted MSB first, passes through the S-box and is written into the 32-bit `sub_word` register.
  - `cnt` increments each cycle. After the cycle with `cnt=3`, the FSM moves to XOR.
  - `busy_o=1`.
- **XOR**
  - One cycle. It computes:
    - `t = sub_word ^ {rcon[round_idx_o+1], 24'h0}`
    - `w0' = w0 ^ t`, `w1' = w1 ^ w0'`, `w2' = w2 ^ w1'`, `w3' = w3 ^ w2'`
  - `round_key_o` is updated, `round_idx_o` increments, and the FSM moves to READY. `busy_o=1` during this state.
- **Priority:** `load_i` beats `next_i` when both are high in the same cycle.
  - `load_i` in SUB or XOR aborts the computation: partial `sub_word` is discarded and round key 0 is loaded from `key_i`.
- `round_idx_o` never exceeds 10 and never wraps.
- **Reset mid-operation:** asynchronous assertion of `rst_n` returns the FSM to IDLE immediately and clears all outputs.

## Timing
- Reset values: `round_key_o=0`, `round_idx_o=0`, `valid_o=0`, `busy_o=0`, `last_o=0`, FSM=IDLE, `cnt=0`.
- **Load latency:** `load_i` high at edge N gives `valid_o=1`, `round_idx_o=0`, `round_key_o=key_i` after edge N.
- **Next latency:** `next_i` accepted at edge N gives the following sequence:
  - `valid_o=0` and `busy_o=1` after edge N.
  - SUB occupies edges N+1..N+4.
  - XOR occupies edge N+5.
  - `valid_o=1` with the new key after edge N+5, so 5 cycles per round key.
- **Full schedule:** a full 0..10 walk with back-to-back `next_i` takes 1 + 10×5 = 51 cycles.
- All outputs are registered; there is no combinational path from any input to any output.
- `round_key_o` holds its previous value during SUB and XOR. Consumers must qualify it with `valid_o`.

## Structure
- Shared package `aes_pkg` holds:
  - the `NR` constant;
  - the Rcon table `rcon[1:10] = 01,02,04,08,10,20,40,80,1b,36`;
  - the FSM enum type `key_fsm_t`.
- Sub-module `aes_sbox`: combinational 8-bit forward S-box, instantiated once here. It is also reusable by the SubByte stage.
- The top level holds the FSM, the byte counter, the `sub_word` register, and the 128-bit key register.

## Test plan
- **FIPS-197 load:** reset, then `load_i` with key `2b7e151628aed2a6abf7158809cf4f3c`.
  - Next cycle: `valid_o=1`, `idx=0`, key echoed.
- **FIPS-197 next:** from the state above, pulse `next_i`.
  - `valid_o` stays low for exactly 5 cycles, then key = `a0fafe1788542cb123a339392a6c7605`, `idx=1`.
- **Full schedule:** keep `next_i` high to the end.
  - `idx=10`, key = `d014f9a8c9ee2589e13f0cc8b6630ca6`, `last_o=1`.
  - Further `next_i` pulses for 20 cycles leave outputs unchanged.
- **All-zero key:** load key 0, then `next_i`.
  - Round 1 key = `62636363626363636263636362636363`.
- **Abort:** assert `load_i` with key 0 in the 3rd SUB cycle of a round-4 computation.
  - After that edge: `idx=0`, key=0, `valid_o=1`, `busy_o=0`.
  - A subsequent `next_i` yields the all-zero round-1 key.
- **Async reset:** drop `rst_n` asynchronously during XOR.
  - All outputs are 0 immediately, without waiting for a clock edge.
  - After release, `next_i` alone has no effect until `load_i` is asserted.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, key-schedule FSM encoding and Rcon lookup.
package aes_pkg;

   localparam int NR = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SUB   = 2'd1,
      ST_XOR   = 2'd2,
      ST_READY = 2'd3
   } key_fsm_t;

   // Round constant for rounds 1..10; other indices never reach the XOR step.
   function automatic logic [7:0] rcon(input logic [3:0] round);
      logic [7:0] r;
      case (round)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in and one byte out.
module aes_sbox (
   input  logic [7:0] in_i,
   output logic [7:0] out_o
);
   import aes_pkg::*;

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign out_o = SBOX[in_i];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per request, SubWord serialised
// through a single S-box (4 SUB cycles + 1 XOR cycle per round).
module aes_key_expand (
   input  logic         clk_i,
   input  logic         rst_n,
   input  logic [127:0] key_i,
   input  logic         load_i,
   input  logic         next_i,
   output logic [127:0] round_key_o,
   output logic [3:0]   round_idx_o,
   output logic         valid_o,
   output logic         busy_o,
   output logic         last_o
);
   import aes_pkg::*;

   key_fsm_t     state_q, state_d;
   logic [1:0]   cnt_q, cnt_d;
   logic [31:0]  sub_word_q, sub_word_d;
   logic [127:0] key_q, key_d;
   logic [3:0]   idx_q, idx_d;
   logic         valid_q, valid_d, busy_q, busy_d, last_q, last_d;
   logic [31:0]  temp_s, t_s, w0_s, w1_s, w2_s, w3_s;
   logic [7:0]   sbox_in_s, sbox_out_s;

   assign temp_s = {key_q[23:0], key_q[31:24]};

   aes_sbox u_sbox (
      .in_i  (sbox_in_s),
      .out_o (sbox_out_s)
   );

   // S-box input byte selection, MSB of the rotated word first
   always_comb begin
      case (cnt_q)
         2'd0:    sbox_in_s = temp_s[31:24];
         2'd1:    sbox_in_s = temp_s[23:16];
         2'd2:    sbox_in_s = temp_s[15:8];
         2'd3:    sbox_in_s = temp_s[7:0];
         default: sbox_in_s = 8'h00;
      endcase
   end

   // XOR-step word chain for the next round key
   always_comb begin
      t_s  = sub_word_q ^ {rcon(idx_q + 4'd1), 24'h000000};
      w0_s = key_q[127:96] ^ t_s;
      w1_s = key_q[95:64]  ^ w0_s;
      w2_s = key_q[63:32]  ^ w1_s;
      w3_s = key_q[31:0]   ^ w2_s;
   end

   // Next-state logic; load has priority over any in-flight computation
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sub_word_d = sub_word_q;
      key_d      = key_q;
      idx_d      = idx_q;
      if (load_i) begin
         state_d = ST_READY;
         cnt_d   = 2'd0;
         key_d   = key_i;
         idx_d   = 4'd0;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_READY: begin
               if (next_i && !last_q) begin
                  state_d = ST_SUB;
                  cnt_d   = 2'd0;
               end else begin
                  state_d = ST_READY;
               end
            end
            ST_SUB: begin
               case (cnt_q)
                  2'd0:    sub_word_d[31:24] = sbox_out_s;
                  2'd1:    sub_word_d[23:16] = sbox_out_s;
                  2'd2:    sub_word_d[15:8]  = sbox_out_s;
                  2'd3:    sub_word_d[7:0]   = sbox_out_s;
                  default: sub_word_d        = sub_word_q;
               endcase
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d = ST_XOR;
               end else begin
                  state_d = ST_SUB;
               end
            end
            ST_XOR: begin
               key_d   = {w0_s, w1_s, w2_s, w3_s};
               idx_d   = idx_q + 4'd1;
               state_d = ST_READY;
            end
            default: state_d = ST_IDLE;
         endcase
      end
      valid_d = (state_d == ST_READY);
      busy_d  = (state_d == ST_SUB) || (state_d == ST_XOR);
      last_d  = valid_d && (idx_d == 4'(NR));
   end

   // State and registered outputs
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 2'd0;
         sub_word_q <= 32'h00000000;
         key_q      <= 128'h0;
         idx_q      <= 4'd0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         last_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sub_word_q <= sub_word_d;
         key_q      <= key_d;
         idx_q      <= idx_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
         last_q     <= last_d;
      end
   end

   assign round_key_o = key_q;
   assign round_idx_o = idx_q;
   assign valid_o     = valid_q;
   assign busy_o      = busy_q;
   assign last_o      = last_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: FIPS-197 / zero-key vectors, latency,
// saturation at round 10, abort by load and asynchronous reset.
module tb_aes_key_expand;

   logic         clk_i = 1'b0;
   logic         rst_n = 1'b0;
   logic [127:0] key_i = 128'h0;
   logic         load_i = 1'b0;
   logic         next_i = 1'b0;
   logic [127:0] round_key_o;
   logic [3:0]   round_idx_o;
   logic         valid_o, busy_o, last_o;

   aes_key_expand dut (
      .clk_i       (clk_i),
      .rst_n       (rst_n),
      .key_i       (key_i),
      .load_i      (load_i),
      .next_i      (next_i),
      .round_key_o (round_key_o),
      .round_idx_o (round_idx_o),
      .valid_o     (valid_o),
      .busy_o      (busy_o),
      .last_o      (last_o)
   );

   always #5 clk_i = ~clk_i;

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
   localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
   localparam logic [127:0] ZERO_R2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;

   typedef struct {
      logic [127:0] key;
      int           rounds;
      logic [127:0] exp_key;
   } vec_t;

   typedef struct {
      logic [127:0] key;
      logic [3:0]   idx;
      logic         last;
   } exp_t;

   vec_t vecs[6];
   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Waits for valid_o; an expired budget is reported as a failed check.
   task automatic wait_valid(output int cycles);
      cycles = 0;
      while (!valid_o && cycles < 40) begin
         tick();
         cycles++;
      end
      if (!valid_o) check("wait_valid_timeout", 128'(valid_o), 128'(1));
   endtask

   task automatic do_load(input logic [127:0] k);
      key_i  = k;
      load_i = 1'b1;
      tick();
      load_i = 1'b0;
   endtask

   task automatic do_next();
      int c;
      next_i = 1'b1;
      tick();
      next_i = 1'b0;
      wait_valid(c);
   endtask

   initial begin
      int   c;
      logic same;
      exp_t e;

      vecs[0] = '{FIPS_KEY, 0, FIPS_KEY};
      vecs[1] = '{FIPS_KEY, 1, FIPS_R1};
      vecs[2] = '{FIPS_KEY, 2, FIPS_R2};
      vecs[3] = '{FIPS_KEY, 10, FIPS_R10};
      vecs[4] = '{128'h0, 1, ZERO_R1};
      vecs[5] = '{128'h0, 2, ZERO_R2};

      // Reset state
      #12;
      check("rst_key",   round_key_o, 128'h0);
      check("rst_idx",   128'(round_idx_o), 128'(0));
      check("rst_valid", 128'(valid_o), 128'(0));
      check("rst_busy",  128'(busy_o), 128'(0));
      check("rst_last",  128'(last_o), 128'(0));
      tick();
      rst_n = 1'b1;
      tick();

      // next_i without a loaded key does nothing
      next_i = 1'b1;
      tick(); tick();
      next_i = 1'b0;
      check("idle_next_valid", 128'(valid_o | busy_o), 128'(0));

      // FIPS load and first round with latency measurement
      do_load(FIPS_KEY);
      check("load_valid", 128'(valid_o), 128'(1));
      check("load_idx",   128'(round_idx_o), 128'(0));
      check("load_key",   round_key_o, FIPS_KEY);
      next_i = 1'b1;
      tick();
      next_i = 1'b0;
      check("next_busy",  128'(busy_o), 128'(1));
      c = 1;
      while (!valid_o && c < 40) begin
         tick();
         c++;
      end
      check("next_latency", 128'(c - 1), 128'(5));
      check("r1_key", round_key_o, FIPS_R1);
      check("r1_idx", 128'(round_idx_o), 128'(1));

      // Full schedule with next_i held high
      next_i = 1'b1;
      c = 0;
      while (!last_o && c < 100) begin
         tick();
         c++;
      end
      check("full_idx",  128'(round_idx_o), 128'(10));
      check("full_key",  round_key_o, FIPS_R10);
      check("full_last", 128'(last_o), 128'(1));
      same = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (round_key_o !== FIPS_R10 || round_idx_o !== 4'd10 || !valid_o || !last_o || busy_o)
            same = 1'b0;
      end
      next_i = 1'b0;
      check("hold_after_last", 128'(same), 128'(1));

      // Table-driven vectors through the scoreboard
      for (int v = 0; v < 6; v++) begin
         do_load(vecs[v].key);
         sb.push_back('{vecs[v].exp_key, 4'(vecs[v].rounds), (vecs[v].rounds == 10)});
         for (int r = 0; r < vecs[v].rounds; r++) do_next();
         if (sb.size() == 0) begin
            check("sb_empty", 128'(0), 128'(1));
         end else begin
            e = sb.pop_front();
            check($sformatf("vec%0d_key", v),  round_key_o, e.key);
            check($sformatf("vec%0d_idx", v),  128'(round_idx_o), 128'(e.idx));
            check($sformatf("vec%0d_last", v), 128'(last_o), 128'(e.last));
         end
      end

      // Abort in the 3rd SUB cycle of the round-4 computation
      do_load(FIPS_KEY);
      for (int r = 0; r < 3; r++) do_next();
      next_i = 1'b1;
      tick();
      next_i = 1'b0;
      tick(); tick();
      key_i  = 128'h0;
      load_i = 1'b1;
      tick();
      load_i = 1'b0;
      check("abort_idx",   128'(round_idx_o), 128'(0));
      check("abort_key",   round_key_o, 128'h0);
      check("abort_valid", 128'(valid_o), 128'(1));
      check("abort_busy",  128'(busy_o), 128'(0));
      do_next();
      check("abort_r1_key", round_key_o, ZERO_R1);

      // Asynchronous reset during XOR
      do_load(FIPS_KEY);
      next_i = 1'b1;
      tick();
      next_i = 1'b0;
      tick(); tick(); tick(); tick();
      check("pre_reset_busy", 128'(busy_o), 128'(1));
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_outputs", {round_key_o[123:0], round_idx_o}, 128'h0);
      check("arst_flags",   128'({valid_o, busy_o, last_o}), 128'(0));
      tick();
      rst_n = 1'b1;
      next_i = 1'b1;
      tick(); tick(); tick();
      next_i = 1'b0;
      check("arst_next_ignored", 128'({valid_o, busy_o, round_idx_o}), 128'(0));
      do_load(FIPS_KEY);
      check("arst_reload", round_key_o, FIPS_KEY);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
